// File: rtl/alu_ctrl_if.sv
// Command and response channels between a client and the alu_ctrl sequencer.
// The client drives the command side and accepts responses; the controller does the reverse.
`timescale 1ns/1ps
interface alu_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4
);
   localparam int AW = $clog2(NREGS);

   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_load;
   logic [2:0]       cmd_op;
   logic [AW-1:0]    cmd_ra;
   logic [AW-1:0]    cmd_rb;
   logic [AW-1:0]    cmd_rd;
   logic             cmd_wb;
   logic [WIDTH-1:0] cmd_imm;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_zero;
   logic [AW-1:0]    rsp_rd;

   modport master (
      output cmd_valid, cmd_load, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_wb, cmd_imm,
      output rsp_ready,
      input  cmd_ready,
      input  rsp_valid, rsp_data, rsp_zero, rsp_rd
   );

   modport slave (
      input  cmd_valid, cmd_load, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_wb, cmd_imm,
      input  rsp_ready,
      output cmd_ready,
      output rsp_valid, rsp_data, rsp_zero, rsp_rd
   );
endinterface

// File: rtl/alu_ctrl.sv
// Sequencer in front of a combinational ALU: operand register file, one-cycle issue,
// result capture with optional write-back, and a held response until it is consumed.
`timescale 1ns/1ps
module alu_ctrl #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_ctrl_if.slave        bus,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero,
   output logic [15:0]      ops_done
);
   localparam int AW = $clog2(NREGS);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_ISSUE = 2'b01;
   localparam logic [1:0] S_RESP  = 2'b10;

   logic [1:0]       state_reg;
   logic [1:0]       state_next;
   logic             wb_reg;
   logic [WIDTH-1:0] alu_a_reg;
   logic [WIDTH-1:0] alu_b_reg;
   logic [2:0]       alu_sel_reg;
   logic [WIDTH-1:0] rsp_data_reg;
   logic             rsp_zero_reg;
   logic [AW-1:0]    rsp_rd_reg;
   logic [15:0]      ops_done_reg;

   logic             cmd_fire;
   logic             rsp_fire;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] rf [NREGS];

   assign cmd_fire = (state_reg == S_IDLE) && bus.cmd_valid;
   assign rsp_fire = (state_reg == S_RESP) && bus.rsp_ready;

   assign bus.cmd_ready = (state_reg == S_IDLE);
   assign bus.rsp_valid = (state_reg == S_RESP);
   assign bus.rsp_data  = rsp_data_reg;
   assign bus.rsp_zero  = rsp_zero_reg;
   assign bus.rsp_rd    = rsp_rd_reg;
   assign alu_a         = alu_a_reg;
   assign alu_b         = alu_b_reg;
   assign alu_sel       = alu_sel_reg;
   assign ops_done      = ops_done_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (cmd_fire) state_next = bus.cmd_load ? S_RESP : S_ISSUE;
         S_ISSUE: state_next = S_RESP;
         S_RESP:  if (rsp_fire) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   // Single write port: loads write at accept, ALU results write at the end of ISSUE.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = bus.cmd_rd;
      wr_data = bus.cmd_imm;
      if (cmd_fire && bus.cmd_load) begin
         wr_en = 1'b1;
      end else if ((state_reg == S_ISSUE) && wb_reg) begin
         wr_en   = 1'b1;
         wr_addr = rsp_rd_reg;
         wr_data = alu_out;
      end
   end

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
         logic [WIDTH-1:0] q_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               q_reg <= '0;
            else if (wr_en && (wr_addr == AW'(gi)))
               q_reg <= wr_data;
         end
         assign rf[gi] = q_reg;
      end
   endgenerate

   // Operands are sampled at accept, so a write-back to ra/rb only affects later commands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_reg       <= 1'b0;
         alu_a_reg    <= '0;
         alu_b_reg    <= '0;
         alu_sel_reg  <= 3'b000;
         rsp_data_reg <= '0;
         rsp_zero_reg <= 1'b0;
         rsp_rd_reg   <= '0;
         ops_done_reg <= 16'd0;
      end else begin
         if (cmd_fire) begin
            rsp_rd_reg <= bus.cmd_rd;
            if (bus.cmd_load) begin
               rsp_data_reg <= bus.cmd_imm;
               rsp_zero_reg <= (bus.cmd_imm == '0);
            end else begin
               alu_a_reg   <= rf[bus.cmd_ra];
               alu_b_reg   <= rf[bus.cmd_rb];
               alu_sel_reg <= bus.cmd_op;
               wb_reg      <= bus.cmd_wb;
            end
         end
         if (state_reg == S_ISSUE) begin
            rsp_data_reg <= alu_out;
            rsp_zero_reg <= alu_zero;
         end
         if (rsp_fire)
            ops_done_reg <= ops_done_reg + 16'd1;
      end
   end
endmodule
